// File: rtl/hehe_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hehe_wb_pkg
//  Description : Shared Wishbone widths and grant-state encoding for the
//                two-master / one-slave interconnect.
//  Revision    : 1.0 - initial release
// ============================================================================
package hehe_wb_pkg;

  localparam int c_DW  = 32;
  localparam int c_AW  = 32;
  localparam int c_BLW = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } grant_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_arb2_rr.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb2_rr
//  Description : Two-way round-robin arbiter with registered grant. A grant
//                is kept while hold is high; otherwise the next winner is
//                chosen from req, ties going to the master that did not win
//                most recently.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb2_rr
  import hehe_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  grant_state_e r_state;
  grant_state_e w_state_nxt;
  logic         r_last_grant;      // 0: m0 won last, 1: m1 won last
  logic         w_last_grant_nxt;

  // Grant state and last winner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;          // m0 wins the first tie after reset
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next grant: keep the owner while it holds, else re-arbitrate immediately
  // so a waiting master takes over without an idle bubble
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    if (!hold) begin
      case (req)
        2'b01: begin
          w_state_nxt      = GNT_M0;
          w_last_grant_nxt = 1'b0;
        end
        2'b10: begin
          w_state_nxt      = GNT_M1;
          w_last_grant_nxt = 1'b1;
        end
        2'b11: begin
          if (r_last_grant) begin
            w_state_nxt      = GNT_M0;
            w_last_grant_nxt = 1'b0;
          end else begin
            w_state_nxt      = GNT_M1;
            w_last_grant_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign gnt = {(r_state == GNT_M1), (r_state == GNT_M0)};

endmodule
`default_nettype wire

// File: rtl/wb_interconnect_2m1s.sv
`default_nettype none
// ============================================================================
//  Module      : wb_interconnect_2m1s
//  Description : Two-master (m0 data, m1 instruction) to one-slave Wishbone
//                interconnect. Round-robin grant, combinational request mux
//                toward the slave and gated ack/last-ack steering back.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_interconnect_2m1s
  import hehe_wb_pkg::*;
#(
  parameter int DW  = c_DW,
  parameter int AW  = c_AW,
  parameter int BLW = c_BLW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // master 0 (data side)
  input  logic [DW-1:0]   m0_wbd_dat_i,
  input  logic [AW-1:0]   m0_wbd_adr_i,
  input  logic [DW/8-1:0] m0_wbd_sel_i,
  input  logic            m0_wbd_we_i,
  input  logic            m0_wbd_cyc_i,
  input  logic            m0_wbd_stb_i,
  output logic [DW-1:0]   m0_wbd_dat_o,
  output logic            m0_wbd_ack_o,
  output logic            m0_wbd_lack_o,
  output logic            m0_wbd_err_o,
  // master 1 (instruction side)
  input  logic [DW-1:0]   m1_wbd_dat_i,
  input  logic [AW-1:0]   m1_wbd_adr_i,
  input  logic [DW/8-1:0] m1_wbd_sel_i,
  input  logic [BLW-1:0]  m1_wbd_bl_i,
  input  logic            m1_wbd_bry_i,
  input  logic            m1_wbd_we_i,
  input  logic            m1_wbd_cyc_i,
  input  logic            m1_wbd_stb_i,
  output logic [DW-1:0]   m1_wbd_dat_o,
  output logic            m1_wbd_ack_o,
  output logic            m1_wbd_lack_o,
  output logic            m1_wbd_err_o,
  // slave
  input  logic [DW-1:0]   s_wbd_dat_i,
  input  logic            s_wbd_ack_i,
  input  logic            s_wbd_lack_i,
  output logic [DW-1:0]   s_wbd_dat_o,
  output logic [AW-1:0]   s_wbd_adr_o,
  output logic [DW/8-1:0] s_wbd_sel_o,
  output logic [BLW-1:0]  s_wbd_bl_o,
  output logic            s_wbd_bry_o,
  output logic            s_wbd_we_o,
  output logic            s_wbd_cyc_o,
  output logic            s_wbd_stb_o
);

  // m0 never bursts: it always presents a single, ready beat
  localparam logic [BLW-1:0] c_M0_BL = BLW'(1);

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_hold;

  assign w_req  = {m1_wbd_cyc_i & m1_wbd_stb_i, m0_wbd_cyc_i & m0_wbd_stb_i};
  // The owner keeps the bus for as long as it holds cyc, bursts included
  assign w_hold = (w_gnt[0] & m0_wbd_cyc_i) | (w_gnt[1] & m1_wbd_cyc_i);

  wb_arb2_rr u_arb (
    .clk  (clk_i),
    .rst  (rst_i),
    .req  (w_req),
    .hold (w_hold),
    .gnt  (w_gnt)
  );

  // Forward the granted master's request to the slave; all zero when idle
  always_comb begin
    s_wbd_dat_o = '0;
    s_wbd_adr_o = '0;
    s_wbd_sel_o = '0;
    s_wbd_bl_o  = '0;
    s_wbd_bry_o = 1'b0;
    s_wbd_we_o  = 1'b0;
    s_wbd_cyc_o = 1'b0;
    s_wbd_stb_o = 1'b0;
    if (w_gnt[0]) begin
      s_wbd_dat_o = m0_wbd_dat_i;
      s_wbd_adr_o = m0_wbd_adr_i;
      s_wbd_sel_o = m0_wbd_sel_i;
      s_wbd_bl_o  = c_M0_BL;
      s_wbd_bry_o = 1'b1;
      s_wbd_we_o  = m0_wbd_we_i;
      s_wbd_cyc_o = m0_wbd_cyc_i;
      s_wbd_stb_o = m0_wbd_stb_i;
    end else if (w_gnt[1]) begin
      s_wbd_dat_o = m1_wbd_dat_i;
      s_wbd_adr_o = m1_wbd_adr_i;
      s_wbd_sel_o = m1_wbd_sel_i;
      s_wbd_bl_o  = m1_wbd_bl_i;
      s_wbd_bry_o = m1_wbd_bry_i;
      s_wbd_we_o  = m1_wbd_we_i;
      s_wbd_cyc_o = m1_wbd_cyc_i;
      s_wbd_stb_o = m1_wbd_stb_i;
    end
  end

  // Return path: read data broadcast, acks steered to the owner only
  assign m0_wbd_dat_o  = s_wbd_dat_i;
  assign m1_wbd_dat_o  = s_wbd_dat_i;
  assign m0_wbd_ack_o  = s_wbd_ack_i  & w_gnt[0];
  assign m0_wbd_lack_o = s_wbd_lack_i & w_gnt[0];
  assign m1_wbd_ack_o  = s_wbd_ack_i  & w_gnt[1];
  assign m1_wbd_lack_o = s_wbd_lack_i & w_gnt[1];
  assign m0_wbd_err_o  = 1'b0;
  assign m1_wbd_err_o  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wb_interconnect_2m1s.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_interconnect_2m1s
//  Description : Directed self-checking bench for wb_interconnect_2m1s.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_interconnect_2m1s;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BLW = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   m0_dat_i = '0;
  logic [AW-1:0]   m0_adr_i = '0;
  logic [DW/8-1:0] m0_sel_i = '0;
  logic            m0_we_i = 1'b0, m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
  logic [DW-1:0]   m0_dat_o;
  logic            m0_ack_o, m0_lack_o, m0_err_o;
  logic [DW-1:0]   m1_dat_i = '0;
  logic [AW-1:0]   m1_adr_i = '0;
  logic [DW/8-1:0] m1_sel_i = '0;
  logic [BLW-1:0]  m1_bl_i = '0;
  logic            m1_bry_i = 1'b0, m1_we_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
  logic [DW-1:0]   m1_dat_o;
  logic            m1_ack_o, m1_lack_o, m1_err_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_ack_i = 1'b0, s_lack_i = 1'b0;
  logic [DW-1:0]   s_dat_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW/8-1:0] s_sel_o;
  logic [BLW-1:0]  s_bl_o;
  logic            s_bry_o, s_we_o, s_cyc_o, s_stb_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_interconnect_2m1s #(.DW(DW), .AW(AW), .BLW(BLW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m0_wbd_dat_i  (m0_dat_i),
    .m0_wbd_adr_i  (m0_adr_i),
    .m0_wbd_sel_i  (m0_sel_i),
    .m0_wbd_we_i   (m0_we_i),
    .m0_wbd_cyc_i  (m0_cyc_i),
    .m0_wbd_stb_i  (m0_stb_i),
    .m0_wbd_dat_o  (m0_dat_o),
    .m0_wbd_ack_o  (m0_ack_o),
    .m0_wbd_lack_o (m0_lack_o),
    .m0_wbd_err_o  (m0_err_o),
    .m1_wbd_dat_i  (m1_dat_i),
    .m1_wbd_adr_i  (m1_adr_i),
    .m1_wbd_sel_i  (m1_sel_i),
    .m1_wbd_bl_i   (m1_bl_i),
    .m1_wbd_bry_i  (m1_bry_i),
    .m1_wbd_we_i   (m1_we_i),
    .m1_wbd_cyc_i  (m1_cyc_i),
    .m1_wbd_stb_i  (m1_stb_i),
    .m1_wbd_dat_o  (m1_dat_o),
    .m1_wbd_ack_o  (m1_ack_o),
    .m1_wbd_lack_o (m1_lack_o),
    .m1_wbd_err_o  (m1_err_o),
    .s_wbd_dat_i   (s_dat_i),
    .s_wbd_ack_i   (s_ack_i),
    .s_wbd_lack_i  (s_lack_i),
    .s_wbd_dat_o   (s_dat_o),
    .s_wbd_adr_o   (s_adr_o),
    .s_wbd_sel_o   (s_sel_o),
    .s_wbd_bl_o    (s_bl_o),
    .s_wbd_bry_o   (s_bry_o),
    .s_wbd_we_o    (s_we_o),
    .s_wbd_cyc_o   (s_cyc_o),
    .s_wbd_stb_o   (s_stb_o)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_dat_i = '0; m0_adr_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    m1_dat_i = '0; m1_adr_i = '0; m1_sel_i = '0; m1_bl_i = '0; m1_bry_i = 0;
    m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    s_dat_i = '0; s_ack_i = 0; s_lack_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_bry_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {s_cyc_o, s_stb_o, s_we_o, s_bry_o});
    end
    checks++;
    if (s_bl_o !== '0 || s_adr_o !== '0) begin
      errors++; $display("FAIL reset_bl_adr got %h/%h exp 0/0", s_bl_o, s_adr_o);
    end
    // a stray slave ack in IDLE must not reach either master
    s_ack_i = 1'b1; s_lack_i = 1'b1;
    #1;
    checks++;
    if ({m0_ack_o, m0_lack_o, m0_err_o, m1_ack_o, m1_lack_o, m1_err_o} !== 6'b0) begin
      errors++; $display("FAIL reset_acks got %b exp 000000",
        {m0_ack_o, m0_lack_o, m0_err_o, m1_ack_o, m1_lack_o, m1_err_o});
    end
    s_ack_i = 1'b0; s_lack_i = 1'b0;
  endtask

  task automatic test_m0_write();
    m0_adr_i = 32'h1000; m0_dat_i = 32'h1; m0_sel_i = 4'hF; m0_we_i = 1;
    m0_cyc_i = 1; m0_stb_i = 1;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL m0wr_pre_grant_cyc got %b exp 0", s_cyc_o);
    end
    tick();
    checks++;
    if ({s_adr_o, s_we_o, s_cyc_o, s_stb_o} !== {32'h1000, 3'b111}) begin
      errors++; $display("FAIL m0wr_fwd got adr %h we/cyc/stb %b exp 1000/111",
        s_adr_o, {s_we_o, s_cyc_o, s_stb_o});
    end
    checks++;
    if ({s_dat_o, s_sel_o, s_bl_o, s_bry_o} !== {32'h1, 4'hF, 10'd1, 1'b1}) begin
      errors++; $display("FAIL m0wr_dat_bl got %h %h %h %b exp 1 f 1 1", s_dat_o, s_sel_o, s_bl_o, s_bry_o);
    end
    checks++;
    if (m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL m0wr_ack_before got %b exp 0", m0_ack_o);
    end
    tick();
    s_ack_i = 1'b1;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      errors++; $display("FAIL m0wr_ack got m0/m1 %b exp 10", {m0_ack_o, m1_ack_o});
    end
    tick();
    s_ack_i = 1'b0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL m0wr_cyc_drop got %b exp 0", s_cyc_o);
    end
    tick();
  endtask

  task automatic test_m1_read();
    m1_adr_i = 32'h0; m1_bl_i = 10'd5; m1_bry_i = 1; m1_sel_i = 4'hF;
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    checks++;
    if ({s_cyc_o, s_we_o, s_bl_o, s_bry_o} !== {1'b1, 1'b0, 10'd5, 1'b1}) begin
      errors++; $display("FAIL m1rd_fwd got cyc %b we %b bl %h bry %b exp 1 0 5 1",
        s_cyc_o, s_we_o, s_bl_o, s_bry_o);
    end
    s_dat_i = 32'h0000_0413; s_ack_i = 1'b1;
    #1;
    checks++;
    if ({m1_dat_o, m1_ack_o, m0_ack_o} !== {32'h0000_0413, 2'b10}) begin
      errors++; $display("FAIL m1rd_data got %h ack m1/m0 %b exp 00000413 10", m1_dat_o, {m1_ack_o, m0_ack_o});
    end
    tick();
    s_ack_i = 1'b0; s_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_adr_i = 32'hA0; m1_adr_i = 32'hB0; m1_bl_i = 10'd2;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    checks++;
    if ({s_adr_o, s_cyc_o} !== {32'hA0, 1'b1}) begin
      errors++; $display("FAIL rr_first_m0 got adr %h cyc %b exp a0 1", s_adr_o, s_cyc_o);
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    checks++;
    if ({s_adr_o, s_cyc_o, s_bl_o} !== {32'hB0, 1'b1, 10'd2}) begin
      errors++; $display("FAIL rr_handover_m1 got adr %h cyc %b bl %h exp b0 1 2", s_adr_o, s_cyc_o, s_bl_o);
    end
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    checks++;
    if ({s_adr_o, s_cyc_o} !== {32'hA0, 1'b1}) begin
      errors++; $display("FAIL rr_tie_m0 got adr %h cyc %b exp a0 1", s_adr_o, s_cyc_o);
    end
    // m0 releases while m1 still waits: m1 takes over on the next edge
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    checks++;
    if (s_adr_o !== 32'hB0) begin
      errors++; $display("FAIL rr_tie_next_m1 got adr %h exp b0", s_adr_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_no_preempt();
    m1_adr_i = 32'h200; m1_bl_i = 10'd4; m1_bry_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    m0_adr_i = 32'h300; m0_cyc_i = 1; m0_stb_i = 1;
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 1'b1; s_lack_i = (i == 3); s_dat_i = 32'h100 + i;
      #1;
      checks++;
      if ({m1_ack_o, m1_lack_o, m0_ack_o, m1_dat_o, s_adr_o} !==
          {1'b1, (i == 3), 1'b0, 32'h100 + i, 32'h200}) begin
        errors++; $display("FAIL burst_beat%0d got ack/lack/m0ack %b dat %h adr %h exp 1%0d0 %h 200",
          i, {m1_ack_o, m1_lack_o, m0_ack_o}, m1_dat_o, s_adr_o, (i == 3), 32'h100 + i);
      end
      tick();
    end
    s_ack_i = 0; s_lack_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    s_ack_i = 1; s_lack_i = 1;
    #1;
    checks++;
    if ({s_adr_o, s_bl_o, m0_ack_o, m0_lack_o, m1_ack_o} !== {32'h300, 10'd1, 3'b110}) begin
      errors++; $display("FAIL burst_then_m0 got adr %h bl %h acks %b exp 300 1 110",
        s_adr_o, s_bl_o, {m0_ack_o, m0_lack_o, m1_ack_o});
    end
    s_lack_i = 0;
  endtask

  task automatic test_reset_mid();
    // still in GNT_M0 with s_ack high from the previous scenario
    rst = 1'b1;
    tick();
    checks++;
    if ({s_cyc_o, m0_ack_o} !== 2'b00) begin
      errors++; $display("FAIL rstmid_idle got cyc/ack %b exp 00", {s_cyc_o, m0_ack_o});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({s_cyc_o, m0_ack_o, s_adr_o} !== {2'b11, 32'h300}) begin
      errors++; $display("FAIL rstmid_regrant got cyc/ack %b adr %h exp 11 300", {s_cyc_o, m0_ack_o}, s_adr_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_idle();
    // stb without cyc, plus junk address/data, is not a request
    m0_stb_i = 1; m1_stb_i = 1; m0_adr_i = 32'hDEAD; m1_adr_i = 32'hBEEF;
    m0_dat_i = 32'h5A5A; m1_bl_i = 10'd7; m1_bry_i = 1; m0_we_i = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({s_cyc_o, s_stb_o, s_we_o, s_bry_o, s_bl_o, s_sel_o, s_adr_o, s_dat_o, m0_err_o, m1_err_o} !== '0) begin
        errors++; $display("FAIL idle_cycle%0d got cyc %b stb %b adr %h dat %h bl %h err %b exp all 0",
          i, s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_bl_o, {m0_err_o, m1_err_o});
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_round_robin();
    test_no_preempt();
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
